// File: rtl/hgcal_input_quant_packer.sv
// HGCAL input stage: 2-bit charge quantizer and frame packer
// feeding the layer-0 neuron LUT vector over valid/ready streams.
module hgcal_input_quant_packer #(
  parameter int NUM_CELLS = 48,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_BITS  = 2,
  parameter int T1        = 16,
  parameter int T2        = 64,
  parameter int T3        = 160
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [IN_WIDTH-1:0]           s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NUM_CELLS*OUT_BITS-1:0] m_data,
  output logic                          err_len
);

  localparam int VW = NUM_CELLS * OUT_BITS;
  localparam int CW = $clog2(NUM_CELLS);
  localparam logic [CW-1:0] LASTC = CW'(NUM_CELLS - 1);
  localparam logic [IN_WIDTH-1:0] TH1 = IN_WIDTH'(T1);
  localparam logic [IN_WIDTH-1:0] TH2 = IN_WIDTH'(T2);
  localparam logic [IN_WIDTH-1:0] TH3 = IN_WIDTH'(T3);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [VW-1:0]  pack, pack_n;
  logic [VW-1:0]  mdata_n;
  logic           mvalid_n;
  logic           err_n;
  logic           drop_q, drop_n;
  logic           ready_en;
  logic           acc;
  logic           out_free;
  logic [OUT_BITS-1:0] code;

  assign code = OUT_BITS'(s_data >= TH1)
              + OUT_BITS'(s_data >= TH2)
              + OUT_BITS'(s_data >= TH3);

  assign s_ready  = ready_en & (state != HOLD);
  assign acc      = s_valid & s_ready;
  assign out_free = ~m_valid | m_ready;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pack_n   = pack;
    mdata_n  = m_data;
    mvalid_n = m_valid;
    err_n    = 1'b0;
    drop_n   = drop_q;
    if (m_valid && m_ready) mvalid_n = 1'b0;
    unique case (state)
      FILL: begin
        if (acc) begin
          pack_n[OUT_BITS*int'(cnt) +: OUT_BITS] = code;
          if (cnt == LASTC) begin
            // missing s_last on the final cell: emit, then skip the tail
            err_n  = ~s_last;
            drop_n = ~s_last;
            if (out_free) begin
              mdata_n  = pack_n;
              mvalid_n = 1'b1;
              cnt_n    = '0;
              state_n  = s_last ? FILL : DROP;
            end else begin
              state_n  = HOLD;
            end
          end else if (s_last) begin
            cnt_n = '0;
            err_n = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          mdata_n  = pack;
          mvalid_n = 1'b1;
          cnt_n    = '0;
          state_n  = drop_q ? DROP : FILL;
        end
      end
      DROP: begin
        if (acc && s_last) state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      cnt      <= '0;
      pack     <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      err_len  <= 1'b0;
      drop_q   <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pack     <= pack_n;
      m_data   <= mdata_n;
      m_valid  <= mvalid_n;
      err_len  <= err_n;
      drop_q   <= drop_n;
      ready_en <= 1'b1;
    end
  end

endmodule

// File: doc/hgcal_input_quant_packer.md
Name: hgcal_input_quant_packer

Overview:
- Upstream input stage of the HGCAL autoencoder: receives one sensor-cell charge per beat over a valid/ready stream.
- Quantizes each cell to a 2-bit code with three programmable thresholds.
- Packs one frame of NUM_CELLS codes into the wide input vector consumed by the layer-0 neuron LUTs; each LUT taps a 4×2-bit slice of this vector.
- Pack buffer and output register are separate, so the next frame is collected while the current vector waits for the layer-0 pipeline.

Parameters:
NUM_CELLS, 48, cells per frame (beats between frame boundaries)
IN_WIDTH, 8, unsigned width of one cell charge
OUT_BITS, 2, code width per cell (fixed at 2; other values unsupported)
T1, 16, lowest threshold, unsigned IN_WIDTH
T2, 64, middle threshold, T1 < T2
T3, 160, top threshold, T2 < T3

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  block can accept a beat
s_data  in  IN_WIDTH  unsigned cell charge
s_last  in  1  final beat of a frame
m_valid  out  1  packed vector valid
m_ready  in  1  layer-0 stage accepts vector
m_data  out  NUM_CELLS*OUT_BITS  packed codes; cell i at bits [2i+1:2i]
err_len  out  1  one-cycle pulse on a malformed frame length

Behaviour:
- Reset (rst=0, async): state=FILL, cnt=0, m_valid=0, m_data=0, err_len=0, pack buffer=0, s_ready=0. s_ready rises on the first clk edge after rst deasserts (registered ready_en flop).
- Quantize (combinational, unsigned compare): code = (s_data>=T1)+(s_data>=T2)+(s_data>=T3), giving 0..3.
- An input beat is accepted when s_valid & s_ready. Each accepted beat writes its code to pack[2*cnt +: 2], then cnt increments.
- FILL state: s_ready=1. The beat with cnt==NUM_CELLS-1 completes the frame.
  - Output free (m_valid==0 or m_ready==1): on that same edge, m_data <= pack including the final code, m_valid<=1, cnt<=0. Latency from final beat accepted to m_valid is 1 cycle.
  - Output busy: go to HOLD; pack retains the full frame.
- HOLD state: s_ready=0. When m_ready is seen high, the output register loads pack on that edge (back-to-back transfer; m_valid stays 1), cnt<=0, go to FILL.
- Output handshake:
  - m_valid&m_ready with no new load: m_valid<=0.
  - m_data is stable while m_valid&~m_ready.
  - m_data holds its last value after consumption; it is not cleared.
- Short frame: s_last on an accepted beat with cnt<NUM_CELLS-1 → discard the partial frame, cnt<=0, err_len pulses 1 cycle, stay in FILL. m_data/m_valid are unaffected.
- Long frame: final beat (cnt==NUM_CELLS-1) accepted with s_last=0 → frame is still output normally, err_len pulses, then go to DROP.
  - DROP state: s_ready=1, beats are discarded until one with s_last is accepted, then go to FILL.
  - If the output was busy at the frame boundary: HOLD first, then DROP.
- Simultaneous frame completion and output consumption in the same cycle is handled by the back-to-back load; no bubble.
- rst asserted mid-frame or in HOLD drops all data and returns to the reset values immediately (async).
- Throughput: 1 beat/cycle sustained while m_ready=1; one vector per NUM_CELLS cycles.

Test Plan:
- Threshold boundaries: frame with cells 0..6 = 15,16,63,64,159,160,255 and the rest 0, m_ready=1 → m_data[13:0]=14'b11_11_10_10_01_01_00, all higher bits 0; m_valid high exactly 1 cycle after the 48th beat.
- Backpressure: hold m_ready=0, send two full frames → s_ready drops after the 48th beat of frame 2 (HOLD). Raise m_ready → frame 1 transferred, frame 2 loaded the next edge with m_valid continuous, then s_ready=1.
- Short frame: s_last on beat 10 → err_len one-cycle pulse, no m_valid. Next clean 48-beat frame outputs correctly with codes starting at bits [1:0].
- Long frame: 52 beats, s_last on beat 52 → vector of the first 48 cells output, err_len pulse at beat 48, beats 49–52 discarded. Following frame is correct.
- Reset mid-operation: assert rst after beat 20, and again while m_valid=1 and m_ready=0 → m_valid=0, m_data=0, s_ready=0 immediately. s_ready=1 one edge after release. Next frame is packed from cell 0.
- Random stream with random s_valid/m_ready gaps, 1000 frames, checked against a reference-model scoreboard → no loss, duplication or reordering.
